// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Shared constants and types for the MIPS32 unified memory arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] PORT_DATA  = 2'd0;
  localparam logic [1:0] PORT_FETCH = 2'd1;
  localparam logic [1:0] PORT_DBG   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  function automatic logic [2:0] port_onehot(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    case (idx)
      PORT_DATA:  v = 3'b001;
      PORT_FETCH: v = 3'b010;
      PORT_DBG:   v = 3'b100;
      default:    v = 3'b000;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_arb_pick                                                        |
// | Combinational winner selection: promoted ports first, then 0>1>2.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mips_arb_pick
  import mips_pkg::*;
(
  input  logic [2:0] i_req_elig,  // requesting and eligible, one bit per port
  input  logic [1:0] i_promo,     // bit0: fetch promoted, bit1: debug promoted
  output logic [1:0] o_idx,
  output logic       o_found
);

  always_comb begin
    o_idx   = PORT_DATA;
    o_found = |i_req_elig;
    // Fetch outranks debug when both have hit the starvation limit.
    if (i_promo[0] && i_req_elig[PORT_FETCH]) begin
      o_idx = PORT_FETCH;
    end else if (i_promo[1] && i_req_elig[PORT_DBG]) begin
      o_idx = PORT_DBG;
    end else if (i_req_elig[PORT_DATA]) begin
      o_idx = PORT_DATA;
    end else if (i_req_elig[PORT_FETCH]) begin
      o_idx = PORT_FETCH;
    end else if (i_req_elig[PORT_DBG]) begin
      o_idx = PORT_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_mem_arbiter                                                     |
// | Three-port arbiter for the unified word memory with fixed latency.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  input  logic                  halt,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int c_LAT_W = $clog2(LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(LATENCY - 1);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [1:0]          r_win;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_LAT_W-1:0]  r_lat_cnt;
  logic [c_CNT_W-1:0]  r_cnt_fetch;
  logic [c_CNT_W-1:0]  r_cnt_dbg;
  logic [2:0]          r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic [2:0]          w_elig;
  logic [1:0]          w_promo;
  logic [1:0]          w_idx;
  logic                w_found;
  logic                w_take;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // A halted pipeline must not fetch; an already latched fetch is unaffected.
  assign w_elig  = {req[PORT_DBG], req[PORT_FETCH] & ~halt, req[PORT_DATA]};
  assign w_promo = {r_cnt_dbg == c_LIMIT, r_cnt_fetch == c_LIMIT};
  assign w_take  = (r_state == ST_IDLE) && w_found;

  mips_arb_pick u_pick (
    .i_req_elig (w_elig),
    .i_promo    (w_promo),
    .o_idx      (w_idx),
    .o_found    (w_found)
  );

  always_comb begin
    w_sel_addr  = addr[0 +: ADDR_W];
    w_sel_wdata = wdata[0 +: DATA_W];
    case (w_idx)
      PORT_FETCH: begin
        w_sel_addr  = addr[ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[DATA_W +: DATA_W];
      end
      PORT_DBG: begin
        w_sel_addr  = addr[2*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    gnt          = 3'b000;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        gnt          = port_onehot(r_win);
        busy         = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (r_lat_cnt == '0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_win     <= PORT_DATA;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat_cnt <= '0;
      r_rvalid  <= 3'b000;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 3'b000;
      if (w_take) begin
        r_win   <= w_idx;
        r_we    <= we[w_idx];
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ST_ISSUE) begin
        r_lat_cnt <= c_LAT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
        r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
      end
      // Writes complete with an acknowledge only; rdata keeps the last read.
      if ((r_state == ST_WAIT) && (r_lat_cnt == '0)) begin
        r_rvalid <= port_onehot(r_win);
        if (!r_we) r_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_cnt_fetch <= '0;
      r_cnt_dbg   <= '0;
    end else begin
      if (!req[PORT_FETCH] || (w_take && (w_idx == PORT_FETCH))) begin
        r_cnt_fetch <= '0;
      end else if (w_elig[PORT_FETCH] && (r_cnt_fetch != c_LIMIT)) begin
        r_cnt_fetch <= r_cnt_fetch + c_CNT_W'(1);
      end
      if (!req[PORT_DBG] || (w_take && (w_idx == PORT_DBG))) begin
        r_cnt_dbg <= '0;
      end else if (r_cnt_dbg != c_LIMIT) begin
        r_cnt_dbg <= r_cnt_dbg + c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
